// File: rtl/letter_segmenter.sv
// letter_segmenter: merges consecutive identical ranked frames into runs and emits per-rank average logits.
// Build macro LETTER_SEG_WORD_END_EN enables the long-hold word-end detector.
module letter_segmenter #(
  parameter int unsigned K       = 3,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned LOGIT_W = 32,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned BLANK   = 26,
  parameter int unsigned MIN_RUN = 6,
  parameter int unsigned END_RUN = 31
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [K*IDX_W-1:0]   i_chars,
  input  logic [K*LOGIT_W-1:0] i_logits,
  output logic                 o_seg_valid,
  input  logic                 i_seg_ready,
  output logic [K*IDX_W-1:0]   o_seg_chars,
  output logic [K*LOGIT_W-1:0] o_seg_logits,
  output logic [CNT_W-1:0]     o_seg_len,
  output logic                 o_word_end,
  output logic                 o_busy
);

  localparam int unsigned SUM_W = LOGIT_W + CNT_W;
  localparam int unsigned IT_W  = $clog2(SUM_W);
  localparam int unsigned RK_W  = (K > 1) ? $clog2(K) : 1;

`ifdef LETTER_SEG_WORD_END_EN
  localparam bit WORD_END_EN = 1'b1;
`else
  localparam bit WORD_END_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IN, S_DIV, S_OUT} state_t;

  state_t state, state_nxt;
  logic   ready_d, seg_valid_d, busy_d;

  logic [K*IDX_W-1:0] run_chars;
  logic [CNT_W-1:0]   run_cnt;
  logic [SUM_W-1:0]   run_sum [K];
  logic               run_live, run_used;

  logic [SUM_W-1:0]   snap_sum [K];
  logic [RK_W-1:0]    div_rank;
  logic [IT_W-1:0]    div_iter;
  logic [SUM_W-1:0]   div_q;
  logic [CNT_W-1:0]   div_rem;

  logic               accept, same, cnt_sat, long_hold, word_end_hit, close_ok, div_last;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SUM_W-1:0]   q_cur, q_nxt;
  logic [CNT_W-1:0]   rem_cur, rem_nxt;
  logic [CNT_W:0]     div_shift;
  logic               div_ge;

  // Frame classification against the live run
  assign accept   = i_valid & o_ready;
  assign same     = run_live & (i_chars == run_chars);
  assign cnt_sat  = (run_cnt == {CNT_W{1'b1}});
  assign cnt_inc  = cnt_sat ? run_cnt : run_cnt + CNT_W'(1);

  assign long_hold = accept & same & ~cnt_sat & ~run_used
                   & (cnt_inc == CNT_W'(END_RUN))
                   & (run_chars[IDX_W-1:0] != IDX_W'(BLANK))
                   & (run_chars[IDX_W +: IDX_W] != IDX_W'(BLANK));
  assign word_end_hit = WORD_END_EN & long_hold;

  assign close_ok = accept & run_live & ~same & ~run_used
                  & (run_cnt >= CNT_W'(MIN_RUN))
                  & (run_chars[IDX_W-1:0] != IDX_W'(BLANK));

  // One restoring-division step per cycle; a new rank reloads its dividend on iteration 0
  assign div_last  = (state == S_DIV) & (div_iter == IT_W'(SUM_W - 1)) & (div_rank == RK_W'(K - 1));
  assign q_cur     = (div_iter == '0) ? snap_sum[div_rank] : div_q;
  assign rem_cur   = (div_iter == '0) ? '0 : div_rem;
  assign div_shift = {rem_cur, q_cur[SUM_W-1]};
  assign div_ge    = (div_shift >= {1'b0, o_seg_len});
  assign rem_nxt   = div_ge ? CNT_W'(div_shift - {1'b0, o_seg_len}) : div_shift[CNT_W-1:0];
  assign q_nxt     = {q_cur[SUM_W-2:0], div_ge};

  // State and registered control outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IN;
      o_ready     <= 1'b1;
      o_seg_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_word_end  <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_ready     <= ready_d;
      o_seg_valid <= seg_valid_d;
      o_busy      <= busy_d;
      o_word_end  <= word_end_hit;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IN:    if (close_ok) state_nxt = S_DIV;
      S_DIV:   if (div_last) state_nxt = S_OUT;
      S_OUT:   if (i_seg_ready) state_nxt = S_IN;
      default: state_nxt = S_IN;
    endcase
  end

  always_comb begin
    ready_d     = 1'b0;
    seg_valid_d = 1'b0;
    busy_d      = 1'b0;
    unique case (state_nxt)
      S_IN:    ready_d = 1'b1;
      S_DIV:   busy_d  = 1'b1;
      S_OUT: begin
        seg_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: ready_d = 1'b1;
    endcase
  end

  // Run accumulation; counter and sums freeze once the count saturates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_chars <= '0;
      run_cnt   <= '0;
      run_live  <= 1'b0;
      run_used  <= 1'b0;
      for (int k = 0; k < int'(K); k++) run_sum[k] <= '0;
    end else if (accept) begin
      if (same) begin
        if (!cnt_sat) begin
          run_cnt <= cnt_inc;
          for (int k = 0; k < int'(K); k++)
            run_sum[k] <= run_sum[k] + SUM_W'(i_logits[k*LOGIT_W +: LOGIT_W]);
        end
        if (word_end_hit) run_used <= 1'b1;
      end else begin
        run_chars <= i_chars;
        run_cnt   <= CNT_W'(1);
        run_live  <= 1'b1;
        run_used  <= 1'b0;
        for (int k = 0; k < int'(K); k++)
          run_sum[k] <= SUM_W'(i_logits[k*LOGIT_W +: LOGIT_W]);
      end
    end
  end

  // Segment snapshot and divider datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seg_chars  <= '0;
      o_seg_len    <= '0;
      o_seg_logits <= '0;
      div_rank     <= '0;
      div_iter     <= '0;
      div_q        <= '0;
      div_rem      <= '0;
      for (int k = 0; k < int'(K); k++) snap_sum[k] <= '0;
    end else if (close_ok) begin
      o_seg_chars <= run_chars;
      o_seg_len   <= run_cnt;
      div_rank    <= '0;
      div_iter    <= '0;
      for (int k = 0; k < int'(K); k++) snap_sum[k] <= run_sum[k];
    end else if (state == S_DIV) begin
      div_q   <= q_nxt;
      div_rem <= rem_nxt;
      if (div_iter == IT_W'(SUM_W - 1)) begin
        o_seg_logits[32'(div_rank)*LOGIT_W +: LOGIT_W] <= q_nxt[LOGIT_W-1:0];
        div_iter <= '0;
        div_rank <= div_rank + RK_W'(1);
      end else begin
        div_iter <= div_iter + IT_W'(1);
      end
    end
  end

endmodule
